gemm_result_writer: RTL and testbench
=====================================

Name: gemm_result_writer

Overview:
Write-back end of the GeMM result path. Each single-cycle result_valid_i pulse carries one finished C block. The block buffers these pulses in a small FIFO, because the producer has no backpressure. It then writes each block to the output SRAM in m-outer, n-inner order through a req/gnt port, and signals done_o once all M_size*N_size blocks have been written.

Parameters:
- AddrWidth, 16: width of the SRAM address, size inputs and block counters.
- DataWidth, 256: width of one flattened C block (result_data_i, sram_wdata_o).
- FifoDepth, 4: number of buffered result entries; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  starts a job; sampled only in Idle
- M_size_i  in  AddrWidth  number of M blocks; latched on start
- N_size_i  in  AddrWidth  number of N blocks; latched on start
- base_addr_i  in  AddrWidth  SRAM address of block (0,0); latched on start
- result_valid_i  in  1  one C block is present on result_data_i
- result_data_i  in  DataWidth  C block payload
- sram_req_o  out  1  write request
- sram_gnt_i  in  1  write accepted this cycle
- sram_addr_o  out  AddrWidth  write address
- sram_wdata_o  out  DataWidth  write data
- M_count_o  out  AddrWidth  m index of the block at the FIFO head
- N_count_o  out  AddrWidth  n index of the block at the FIFO head
- busy_o  out  1  high in Run and Done
- done_o  out  1  single-cycle completion pulse
- overflow_o  out  1  sticky flag: a result was dropped

Behaviour:
- Reset values: all outputs 0, FIFO empty, state Idle, latched sizes and base 0.
- States:
  - Idle: on start_i, latch M/N/base, clear counters, FIFO and overflow_o. If M_size_i==0 or N_size_i==0, go to Done; otherwise go to Run.
  - Run: push and write. Go to Done in the cycle after the last block's grant.
  - Done: done_o=1 for one cycle, then go to Idle.
- start_i is ignored outside Idle. result_valid_i is ignored in Idle and Done, and does not set overflow.
- Push: in Run, result_valid_i writes result_data_i into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the data is dropped and overflow_o is set.
  - Push and pop in the same cycle while full is legal: occupancy is unchanged and nothing is dropped.
- Results beyond M_size*N_size are dropped and set overflow_o. Total-received is counted at 2*AddrWidth width.
- Write handshake:
  - sram_req_o = FIFO not empty and state Run. sram_wdata_o = FIFO head.
  - Address, data and request stay stable until sram_gnt_i. A grant pops the FIFO.
  - sram_gnt_i while sram_req_o is low is ignored.
- Latency: a result pushed in cycle t appears on sram_req_o at t+1 at the earliest, because the FIFO output is registered and there is no bypass.
- Address: sram_addr_o = base + m*N_size + n, held as a running linear offset that increments by 1 on each grant. Wraps mod 2^AddrWidth.
- Counters: on grant, N_count increments. When N_count reaches N_size-1 it wraps to 0 and M_count increments.
- Last write: grant with M_count==M_size-1 and N_count==N_size-1.
- The full product M_size*N_size is computed at 2*AddrWidth width. No truncation is allowed in the termination check.
- overflow_o is cleared only by start_i or reset.

Optional Feature:
- Macro GEMM_WRITER_STRIDE_EN.
- When defined: adds input row_stride_i (AddrWidth), latched on start. Address = base + m*row_stride + n, with a row-base register incremented by row_stride on each m-wrap.
- When undefined: the port does not exist and addressing is linear, i.e. row_stride is effectively N_size.

Decomposition:
- Package gemm_writer_pkg: state enum writer_state_t {WriterIdle, WriterRun, WriterDone} and a localparam for the FIFO pointer width, $clog2(FifoDepth).
- Sub-module gemm_result_fifo:
  - Parameters: DataWidth, Depth.
  - Ports: push, pop, data in/out, full, empty.
  - Pointers one bit wider than the index, used for the full/empty test.

Test Plan:
- M=2, N=3, base=0x100, gnt tied high, 6 spaced pulses with data 1..6 -> writes to 0x100..0x105 with data 1..6; done_o pulses one cycle after the sixth grant; overflow_o=0.
- FifoDepth=4, gnt held low, 5 back-to-back pulses -> first 4 stored, fifth dropped, overflow_o=1; release gnt -> 4 writes at base..base+3.
- FIFO full, push and grant in the same cycle -> occupancy stays 4, overflow_o stays 0, data order preserved.
- M=0, N=5, start -> busy_o high for one cycle, done_o pulses, no sram_req_o.
- M=1, N=2, 3 pulses -> 2 writes, third dropped, overflow_o=1; start_i pulsed in Run is ignored.
- Reset asserted mid-job after 2 of 4 writes -> all outputs 0 at once, FIFO empty; a new start then writes from base.
- With GEMM_WRITER_STRIDE_EN: M=2, N=2, stride=8, base=0 -> addresses 0,1,8,9.

Source files
------------

// File: rtl/gemm_writer_pkg.sv
// Shared types and constants for the GeMM result writer.
//   writer_state_t   : top-level sequencing states
//   DefaultFifoDepth : default number of buffered result entries
//   FifoPtrWidth     : FIFO index width for the default depth
package gemm_writer_pkg;

  typedef enum logic [1:0] {
    WriterIdle,
    WriterRun,
    WriterDone
  } writer_state_t;

  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned FifoPtrWidth     = $clog2(DefaultFifoDepth);

  // Width of a counter able to hold the product of two AddrWidth-wide sizes.
  function automatic int unsigned prod_width(input int unsigned addr_width);
    return 2 * addr_width;
  endfunction

endpackage

// File: rtl/gemm_result_fifo.sv
// Small synchronous FIFO buffering finished C blocks.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush to empty
//   push_i/data_i : write one entry (accepted when not full, or when popping this cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   data_o        : head entry, read from registered storage (no bypass)
//   full_o/empty_o: occupancy flags
// Depth must be a power of 2 and at least 2.
module gemm_result_fifo #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam logic [IdxW:0] PtrOne = (IdxW + 1)'(1);

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [IdxW:0]        wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] mem_q [Depth];
  logic                 do_push, do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
              (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so push while full is fine then.
    do_push = push_i && (!full_o || do_pop);
    data_o  = mem_q[rd_ptr_q[IdxW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
  end

endmodule

// File: rtl/gemm_result_writer.sv
// Write-back end of the GeMM result path. Buffers single-cycle result pulses
// (no producer backpressure) and writes them to SRAM in m-outer, n-inner order.
//   start_i, M_size_i, N_size_i, base_addr_i : job setup, sampled in Idle
//   row_stride_i                             : row pitch (GEMM_WRITER_STRIDE_EN only)
//   result_valid_i, result_data_i            : incoming C blocks
//   sram_req_o/gnt_i/addr_o/wdata_o          : SRAM write port, held until grant
//   M_count_o, N_count_o                     : block index at the FIFO head
//   busy_o, done_o, overflow_o               : status; overflow is sticky until start
// Optional macro GEMM_WRITER_STRIDE_EN adds a programmable row stride; without it
// addressing is linear (row stride equals N_size).
module gemm_result_writer
  import gemm_writer_pkg::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned FifoDepth = DefaultFifoDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] base_addr_i,
`ifdef GEMM_WRITER_STRIDE_EN
  input  logic [AddrWidth-1:0] row_stride_i,
`endif
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_data_i,
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [AddrWidth-1:0] M_count_o,
  output logic [AddrWidth-1:0] N_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  localparam int unsigned CntWidth = prod_width(AddrWidth);
  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
  localparam logic [CntWidth-1:0]  CntOne  = CntWidth'(1);

  writer_state_t        state_q;
  logic [AddrWidth-1:0] m_size_q, n_size_q, base_q;
  logic [AddrWidth-1:0] m_cnt_q, n_cnt_q;
  logic [CntWidth-1:0]  total_q, pushed_q;
  logic                 overflow_q;
`ifdef GEMM_WRITER_STRIDE_EN
  logic [AddrWidth-1:0] stride_q, row_base_q;
`else
  logic [AddrWidth-1:0] offset_q;
`endif

  logic                 in_run, fifo_clear, fifo_full, fifo_empty;
  logic                 req, grant, n_last, m_last, excess, push_ok, drop;
  logic [DataWidth-1:0] fifo_head;

  always_comb begin
    in_run     = (state_q == WriterRun);
    fifo_clear = (state_q == WriterIdle) && start_i;
    req        = in_run && !fifo_empty;
    // A grant without a request is ignored.
    grant      = req && sram_gnt_i;
    n_last     = (n_cnt_q == n_size_q - AddrOne);
    m_last     = (m_cnt_q == m_size_q - AddrOne);
    // Full-width compare so large M*N never truncates.
    excess     = (pushed_q >= total_q);
    push_ok    = in_run && result_valid_i && !excess && (!fifo_full || grant);
    drop       = in_run && result_valid_i && !push_ok;
  end

  gemm_result_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (fifo_clear),
    .push_i  (push_ok),
    .pop_i   (grant),
    .data_i  (result_data_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WriterIdle;
      m_size_q   <= '0;
      n_size_q   <= '0;
      base_q     <= '0;
      m_cnt_q    <= '0;
      n_cnt_q    <= '0;
      total_q    <= '0;
      pushed_q   <= '0;
      overflow_q <= 1'b0;
`ifdef GEMM_WRITER_STRIDE_EN
      stride_q   <= '0;
      row_base_q <= '0;
`else
      offset_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        WriterIdle: begin
          if (start_i) begin
            m_size_q   <= M_size_i;
            n_size_q   <= N_size_i;
            base_q     <= base_addr_i;
            m_cnt_q    <= '0;
            n_cnt_q    <= '0;
            total_q    <= CntWidth'(M_size_i) * CntWidth'(N_size_i);
            pushed_q   <= '0;
            overflow_q <= 1'b0;
`ifdef GEMM_WRITER_STRIDE_EN
            stride_q   <= row_stride_i;
            row_base_q <= '0;
`else
            offset_q   <= '0;
`endif
            state_q    <= (M_size_i == '0 || N_size_i == '0) ? WriterDone : WriterRun;
          end
        end
        WriterRun: begin
          if (push_ok) pushed_q <= pushed_q + CntOne;
          if (drop)    overflow_q <= 1'b1;
          if (grant) begin
`ifndef GEMM_WRITER_STRIDE_EN
            offset_q <= offset_q + AddrOne;
`endif
            if (n_last) begin
              n_cnt_q <= '0;
              m_cnt_q <= m_cnt_q + AddrOne;
`ifdef GEMM_WRITER_STRIDE_EN
              row_base_q <= row_base_q + stride_q;
`endif
            end else begin
              n_cnt_q <= n_cnt_q + AddrOne;
            end
            if (n_last && m_last) state_q <= WriterDone;
          end
        end
        WriterDone: state_q <= WriterIdle;
        default:    state_q <= WriterIdle;
      endcase
    end
  end

  always_comb begin
`ifdef GEMM_WRITER_STRIDE_EN
    sram_addr_o = base_q + row_base_q + n_cnt_q;
`else
    sram_addr_o = base_q + offset_q;
`endif
    sram_req_o   = req;
    // Head storage is not reset; keep the bus quiet when nothing is requested.
    sram_wdata_o = req ? fifo_head : '0;
    M_count_o    = m_cnt_q;
    N_count_o    = n_cnt_q;
    busy_o       = (state_q != WriterIdle);
    done_o       = (state_q == WriterDone);
    overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_gemm_result_writer.sv
module tb_gemm_result_writer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] M_size_i, N_size_i, base_addr_i;
`ifdef GEMM_WRITER_STRIDE_EN
  logic [AW-1:0] row_stride_i;
`endif
  logic          result_valid_i;
  logic [DW-1:0] result_data_i;
  logic          sram_req_o, sram_gnt_i;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [AW-1:0] M_count_o, N_count_o;
  logic          busy_o, done_o, overflow_o;

  gemm_result_writer #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .FifoDepth (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .M_size_i       (M_size_i),
    .N_size_i       (N_size_i),
    .base_addr_i    (base_addr_i),
`ifdef GEMM_WRITER_STRIDE_EN
    .row_stride_i   (row_stride_i),
`endif
    .result_valid_i (result_valid_i),
    .result_data_i  (result_data_i),
    .sram_req_o     (sram_req_o),
    .sram_gnt_i     (sram_gnt_i),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .M_count_o      (M_count_o),
    .N_count_o      (N_count_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] m;
    logic [AW-1:0] n;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec  = 0;
  int          n_fail = 0;
  int unsigned last_gnt_cyc = 0;

  function automatic logic [DW-1:0] pat(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {32{b}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every accepted write is compared against the queue head.
  always @(negedge clk_i) begin
    if (rst_ni && sram_req_o && sram_gnt_i) begin
      last_gnt_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h written, no write expected", sram_addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", DW'(sram_addr_o), DW'(mon_e.addr));
        check("wr_data", sram_wdata_o, mon_e.data);
        check("wr_m_count", DW'(M_count_o), DW'(mon_e.m));
        check("wr_n_count", DW'(N_count_o), DW'(mon_e.n));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int m, input int n, input int base, input int stride);
    M_size_i    = AW'(m);
    N_size_i    = AW'(n);
    base_addr_i = AW'(base);
`ifdef GEMM_WRITER_STRIDE_EN
    row_stride_i = AW'(stride);
`else
    if (stride < 0) $display("negative stride ignored");
`endif
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic pulse(input int v);
    result_valid_i = 1'b1;
    result_data_i  = pat(v);
    cyc();
    result_valid_i = 1'b0;
  endtask

  task automatic expect_wr(input int addr, input int v, input int m, input int n);
    exp_t e;
    e.addr = AW'(addr);
    e.data = pat(v);
    e.m    = AW'(m);
    e.n    = AW'(n);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        if (chk_lat) check({name, "_done_latency"}, DW'(cyc_cnt), DW'(last_gnt_cyc + 1));
        check({name, "_sb_empty"}, DW'(exp_q.size()), DW'(0));
        return;
      end
    end
    n_vec++;
    n_fail++;
    $display("FAIL %s_done_timeout: done_o not seen, required within 200 cycles", name);
    exp_q.delete();
  endtask

  initial begin
    rst_ni         = 1'b0;
    start_i        = 1'b0;
    M_size_i       = '0;
    N_size_i       = '0;
    base_addr_i    = '0;
`ifdef GEMM_WRITER_STRIDE_EN
    row_stride_i   = '0;
`endif
    result_valid_i = 1'b0;
    result_data_i  = '0;
    sram_gnt_i     = 1'b0;

    // Reset state
    #1;
    check("rst_req", DW'(sram_req_o), DW'(0));
    check("rst_busy", DW'(busy_o), DW'(0));
    check("rst_done", DW'(done_o), DW'(0));
    check("rst_ovf", DW'(overflow_o), DW'(0));
    check("rst_addr", DW'(sram_addr_o), DW'(0));
    check("rst_wdata", sram_wdata_o, DW'(0));
    check("rst_counts", DW'({M_count_o, N_count_o}), DW'(0));
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();

    // T1: M=2 N=3 base 0x100, grant tied high, spaced pulses
    start_job(2, 3, 'h100, 3);
    sram_gnt_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      expect_wr('h100 + i - 1, i, (i - 1) / 3, (i - 1) % 3);
      pulse(i);
      cyc();
    end
    wait_done("t1", 1'b1);
    check("t1_ovf", DW'(overflow_o), DW'(0));
    check("t1_busy_in_done", DW'(busy_o), DW'(1));
    cyc();
    check("t1_done_one_cycle", DW'(done_o), DW'(0));
    check("t1_idle", DW'(busy_o), DW'(0));

    // T2: grant held low, five back-to-back pulses into a depth-4 FIFO
    start_job(2, 4, 'h200, 4);
    sram_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_wr('h200 + i, 'h11 + i, 0, i);
      pulse('h11 + i);
    end
    @(negedge clk_i);
    check("t2_ovf_set", DW'(overflow_o), DW'(1));
    check("t2_req", DW'(sram_req_o), DW'(1));
    check("t2_addr", DW'(sram_addr_o), DW'('h200));
    cyc();
    cyc();
    @(negedge clk_i);
    check("t2_addr_hold", DW'(sram_addr_o), DW'('h200));
    check("t2_data_hold", sram_wdata_o, pat('h11));
    cyc();
    sram_gnt_i = 1'b1;
    repeat (4) cyc();
    for (int i = 4; i < 8; i++) begin
      expect_wr('h200 + i, 'h21 + i, i / 4, i % 4);
      pulse('h21 + i);
      cyc();
    end
    wait_done("t2", 1'b1);
    check("t2_ovf_sticky", DW'(overflow_o), DW'(1));
    cyc();
    sram_gnt_i = 1'b0;

    // T3: FIFO full, push and grant in the same cycle
    start_job(1, 8, 'h300, 8);
    check("t3_ovf_cleared", DW'(overflow_o), DW'(0));
    for (int i = 0; i < 4; i++) begin
      expect_wr('h300 + i, 'h31 + i, 0, i);
      pulse('h31 + i);
    end
    expect_wr('h304, 'h35, 0, 4);
    sram_gnt_i     = 1'b1;
    result_valid_i = 1'b1;
    result_data_i  = pat('h35);
    cyc();
    result_valid_i = 1'b0;
    sram_gnt_i     = 1'b0;
    @(negedge clk_i);
    check("t3_no_drop", DW'(overflow_o), DW'(0));
    cyc();
    pulse('h36);
    @(negedge clk_i);
    check("t3_still_full", DW'(overflow_o), DW'(1));
    cyc();
    sram_gnt_i = 1'b1;
    repeat (4) cyc();
    for (int i = 5; i < 8; i++) begin
      expect_wr('h300 + i, 'h37 + i - 5, 0, i);
      pulse('h37 + i - 5);
      cyc();
    end
    wait_done("t3", 1'b1);
    cyc();
    sram_gnt_i = 1'b0;

    // T4: zero-sized job goes straight to Done
    start_job(0, 5, 'h40, 5);
    @(negedge clk_i);
    check("t4_busy", DW'(busy_o), DW'(1));
    check("t4_done", DW'(done_o), DW'(1));
    check("t4_req", DW'(sram_req_o), DW'(0));
    cyc();
    check("t4_busy_after", DW'(busy_o), DW'(0));
    check("t4_done_after", DW'(done_o), DW'(0));

    // T5: excess result dropped, start in Run ignored
    start_job(1, 2, 'h400, 2);
    sram_gnt_i  = 1'b1;
    M_size_i    = AW'(5);
    N_size_i    = AW'(5);
    base_addr_i = '0;
    start_i     = 1'b1;
    cyc();
    start_i = 1'b0;
    expect_wr('h400, 'h51, 0, 0);
    expect_wr('h401, 'h52, 0, 1);
    pulse('h51);
    pulse('h52);
    pulse('h53);
    wait_done("t5", 1'b1);
    check("t5_ovf", DW'(overflow_o), DW'(1));
    cyc();
    check("t5_idle", DW'(busy_o), DW'(0));
    sram_gnt_i = 1'b0;

    // T6: reset mid-job, then a fresh job from its base
    start_job(1, 4, 'h500, 4);
    sram_gnt_i = 1'b1;
    expect_wr('h500, 'h61, 0, 0);
    expect_wr('h501, 'h62, 0, 1);
    pulse('h61);
    cyc();
    pulse('h62);
    cyc();
    sram_gnt_i = 1'b0;
    pulse('h63);
    cyc();
    @(negedge clk_i);
    check("t6_req_pre", DW'(sram_req_o), DW'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_req", DW'(sram_req_o), DW'(0));
    check("t6_busy", DW'(busy_o), DW'(0));
    check("t6_done", DW'(done_o), DW'(0));
    check("t6_addr", DW'(sram_addr_o), DW'(0));
    check("t6_wdata", sram_wdata_o, DW'(0));
    check("t6_counts", DW'({M_count_o, N_count_o}), DW'(0));
    check("t6_sb_empty", DW'(exp_q.size()), DW'(0));
    cyc();
    rst_ni = 1'b1;
    cyc();
    check("t6_fifo_empty", DW'(sram_req_o), DW'(0));
    start_job(1, 2, 'h600, 2);
    sram_gnt_i = 1'b1;
    expect_wr('h600, 'h71, 0, 0);
    expect_wr('h601, 'h72, 0, 1);
    pulse('h71);
    cyc();
    pulse('h72);
    wait_done("t6", 1'b1);
    cyc();
    sram_gnt_i = 1'b0;

`ifdef GEMM_WRITER_STRIDE_EN
    // T7: strided rows
    start_job(2, 2, 0, 8);
    sram_gnt_i = 1'b1;
    expect_wr(0, 'h81, 0, 0);
    expect_wr(1, 'h82, 0, 1);
    expect_wr(8, 'h83, 1, 0);
    expect_wr(9, 'h84, 1, 1);
    for (int i = 0; i < 4; i++) begin
      pulse('h81 + i);
      cyc();
    end
    wait_done("t7", 1'b1);
    cyc();
    sram_gnt_i = 1'b0;
`endif

    repeat (3) cyc();
    check("sb_drained", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
